// File: rtl/ms_riscv32_mp_pkg.sv
// rtl/ms_riscv32_mp_pkg.sv - shared constants for the ms_riscv32_mp core
//
// Purpose: canonical NOP encoding, base opcode values and the bit positions
// of the RV32 instruction fields. The decode-side blocks import this package.
// Ports: none (package).

package ms_riscv32_mp_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] SYSTEM = 7'h73;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;
  localparam int CSR_LSB    = 20;
  localparam int CSR_MSB    = 31;
  // Everything above the opcode, handed on for immediate assembly.
  localparam int BODY_LSB   = 7;
  localparam int BODY_MSB   = 31;

endpackage

// File: rtl/instr_field_split.sv
// rtl/instr_field_split.sv - combinational RV32 instruction field splitter
//
// Purpose: slices a 32-bit instruction into its fixed-position fields.
// Ports:
//   instr_in      in  ILEN  instruction to split
//   opcode_out    out 7     instr[6:0]
//   funct3_out    out 3     instr[14:12]
//   funct7_out    out 7     instr[31:25]
//   rs1addr_out   out 5     instr[19:15]
//   rs2addr_out   out 5     instr[24:20]
//   rdaddr_out    out 5     instr[11:7]
//   csr_addr_out  out 12    instr[31:20]
//   instr_out     out 25    instr[31:7]

module instr_field_split
  import ms_riscv32_mp_pkg::*;
#(
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0] instr_in,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [4:0]      rs1addr_out,
  output logic [4:0]      rs2addr_out,
  output logic [4:0]      rdaddr_out,
  output logic [11:0]     csr_addr_out,
  output logic [24:0]     instr_out
);

  assign opcode_out   = instr_in[OPCODE_MSB:OPCODE_LSB];
  assign funct3_out   = instr_in[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7_out   = instr_in[FUNCT7_MSB:FUNCT7_LSB];
  assign rs1addr_out  = instr_in[RS1_MSB:RS1_LSB];
  assign rs2addr_out  = instr_in[RS2_MSB:RS2_LSB];
  assign rdaddr_out   = instr_in[RD_MSB:RD_LSB];
  assign csr_addr_out = instr_in[CSR_MSB:CSR_LSB];
  assign instr_out    = instr_in[BODY_MSB:BODY_LSB];

endmodule

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - fetch-to-decode {pc, instr} FIFO with flush and field split
//
// Purpose: DEPTH-entry FIFO between instruction-memory response and decode.
// The head entry is split into decode fields; NOP is shown when empty/flushing.
// Ports:
//   ms_riscv32_mp_clk_in  in   clock, rising edge
//   ms_riscv32_mp_rst_in  in   asynchronous active-high reset
//   flush_in              in   synchronous flush (drops queue and any push)
//   in_valid_in/in_ready_out, instr_in, pc_in   fetch-side handshake and data
//   out_valid_out/out_ready_in                  decode-side handshake
//   opcode_out .. instr_out                     head instruction fields
//   pc_out                                      head PC, 0 when not valid
//   count_out                                   occupied entries

module instr_decode_queue #(
  parameter int          ILEN      = 32,
  parameter int          PC_WIDTH  = 32,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = ms_riscv32_mp_pkg::NOP_INSTR
) (
  input  logic                   ms_riscv32_mp_clk_in,
  input  logic                   ms_riscv32_mp_rst_in,
  input  logic                   flush_in,
  input  logic                   in_valid_in,
  output logic                   in_ready_out,
  input  logic [ILEN-1:0]        instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   out_valid_out,
  input  logic                   out_ready_in,
  output logic [6:0]             opcode_out,
  output logic [2:0]             funct3_out,
  output logic [6:0]             funct7_out,
  output logic [4:0]             rs1addr_out,
  output logic [4:0]             rs2addr_out,
  output logic [4:0]             rdaddr_out,
  output logic [11:0]            csr_addr_out,
  output logic [24:0]            instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ILEN-1:0]     r_instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [ILEN-1:0]     w_head_instr;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // No bypass when full: ready drops at count == DEPTH even if decode pops.
  assign in_ready_out  = !w_full && !flush_in;
  assign out_valid_out = !w_empty && !flush_in;

  assign w_push = in_valid_in && in_ready_out;
  assign w_pop  = out_valid_out && out_ready_in;

  // Storage is not reset; contents are only ever read behind a valid count.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= instr_in;
      r_pc_mem[r_wr_ptr]    <= pc_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // out_valid_out already folds in flush, so one select covers empty and flush.
  assign w_head_instr = out_valid_out ? r_instr_mem[r_rd_ptr] : NOP_INSTR[ILEN-1:0];
  assign pc_out       = out_valid_out ? r_pc_mem[r_rd_ptr] : '0;
  assign count_out    = r_count;

  instr_field_split #(
    .ILEN (ILEN)
  ) u_field_split (
    .instr_in     (w_head_instr),
    .opcode_out   (opcode_out),
    .funct3_out   (funct3_out),
    .funct7_out   (funct7_out),
    .rs1addr_out  (rs1addr_out),
    .rs2addr_out  (rs2addr_out),
    .rdaddr_out   (rdaddr_out),
    .csr_addr_out (csr_addr_out),
    .instr_out    (instr_out)
  );

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised fetch-to-decode instruction buffer: a DEPTH-entry FIFO of {pc, instr} pairs with valid/ready handshakes on both sides.
- Adds a synchronous flush that empties the queue.
- The head entry is split into decode fields. When the queue is empty or flushing, the fields show the canonical NOP.
- Sits between the instruction-memory response and the decode/register-file read stage of the ms_riscv32_mp core.

Parameters:
- ILEN, 32, instruction width in bits; must be 32.
- PC_WIDTH, 32, program-counter width.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- NOP_INSTR, 32'h00000013, instruction presented when empty or flushing (addi x0,x0,0).

Ports:
- ms_riscv32_mp_clk_in  in  1  clock; all state on rising edge.
- ms_riscv32_mp_rst_in  in  1  asynchronous, active-high reset.
- flush_in  in  1  synchronous queue flush.
- in_valid_in  in  1  fetch side presents an entry.
- in_ready_out  out  1  queue can accept an entry.
- instr_in  in  ILEN  fetched instruction.
- pc_in  in  PC_WIDTH  PC of the fetched instruction.
- out_valid_out  out  1  head entry valid.
- out_ready_in  in  1  decode consumes the head entry.
- opcode_out  out  7  head instr[6:0].
- funct3_out  out  3  head instr[14:12].
- funct7_out  out  7  head instr[31:25].
- rs1addr_out  out  5  head instr[19:15].
- rs2addr_out  out  5  head instr[24:20].
- rdaddr_out  out  5  head instr[11:7].
- csr_addr_out  out  12  head instr[31:20].
- instr_out  out  25  head instr[31:7].
- pc_out  out  PC_WIDTH  head PC; 0 when not valid.
- count_out  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - count 0, read/write pointers 0, out_valid_out 0, in_ready_out 1.
  - Field outputs decode NOP_INSTR (opcode 7'h13, all other fields 0); pc_out 0.
  - Storage contents need not be cleared.
- Handshakes:
  - Push occurs when in_valid_in && in_ready_out. Pop occurs when out_valid_out && out_ready_in.
  - in_ready_out = (count < DEPTH) && !flush_in. There is no bypass when full: a pop and a push in the same cycle on a full queue is not allowed, because ready is low.
  - out_valid_out = (count != 0) && !flush_in.
- Latency: an entry pushed in cycle N is visible at the head in N+1. There is no combinational in-to-out path.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH using natural binary wrap, since DEPTH is a power of two.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Empty: out_valid_out 0, fields show NOP, pc_out 0. A pop request is ignored.
- Full: count == DEPTH, in_ready_out 0, and the input is held off by the source.
- Flush:
  - In the flush_in cycle, outputs combinationally show the NOP fields, out_valid_out 0 and in_ready_out 0.
  - On the clock edge, count and both pointers go to 0.
  - Any in_valid_in in that cycle is dropped.
  - The queue accepts again in the next cycle.
  - Flush dominates push and pop.
- Field decode is purely combinational from the head entry, or from NOP_INSTR when empty or flushing.

Decomposition:
- Shared package ms_riscv32_mp_pkg holds:
  - NOP_INSTR constant.
  - Opcode localparams: OP_IMM 7'h13, OP 7'h33, LOAD 7'h03, STORE 7'h23, BRANCH 7'h63, SYSTEM 7'h73.
  - Field bit-position constants.
- One combinational sub-module, instr_field_split: takes ILEN bits in and produces the opcode, funct3, funct7, rs1, rs2, rd, csr and instr[31:7] outputs. Reused elsewhere in the core.
- FIFO storage and pointer logic stay in the top module.

Test Plan:
- Reset state: assert rst mid-stream with count 2 -> immediately out_valid 0, count 0, opcode 7'h13, rd 0, pc_out 0, in_ready 1.
- Single transfer: push instr 32'h00500093 at pc 32'h100 -> next cycle out_valid 1, opcode 7'h13, rd 1, rs1 0, csr_addr 12'h005, pc_out 32'h100. Pop clears the entry.
- Fill and backpressure with DEPTH=2, out_ready 0: push 32'h002081b3 then 32'h40208233 -> count 2, in_ready 0; a third push is held until a pop. Release out_ready -> entries emerge in order:
  - funct7 0 first, then funct7 7'h20.
  - rd 3, then rd 4.
- Concurrent push/pop at count 1 for 8 cycles -> count stays 1; all 8 PCs are output in order; the pointers wrap at least twice.
- Flush: count 2 with a simultaneous push and flush_in -> in the flush cycle out_valid 0 and NOP fields; next cycle count 0. The pushed instruction never appears; a push the following cycle is accepted.
- Parameter sweep: DEPTH=4 and DEPTH=8 -> count_out reaches DEPTH, in_ready deasserts exactly at full, and ordering is preserved across wrap.
